sipo_buf_reader: RTL and testbench



---
 rtl/sipo_buf_reader_if.sv | 26 ++
 rtl/sipo_buf_reader.sv | 182 ++++++++++++++++++
 tb/tb_sipo_buf_reader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_buf_reader_if.sv
// Buffer op handshake plus the outgoing word stream of the SIPO buffer reader.
// master = reader side, slave = buffer/consumer side.
`timescale 1ns/1ps
interface sipo_buf_reader_if #(
  parameter int DATA_W = 32
);
  logic              buf_val_op;
  logic              buf_op;
  logic              buf_op_ack;
  logic              buf_op_commit;
  logic [DATA_W-1:0] buf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output buf_val_op, buf_op, out_valid, out_data, out_last,
    input  buf_op_ack, buf_op_commit, buf_rdata, out_ready
  );

  modport slave (
    input  buf_val_op, buf_op, out_valid, out_data, out_last,
    output buf_op_ack, buf_op_commit, buf_rdata, out_ready
  );
endinterface

// File: rtl/sipo_buf_reader.sv
// Drains word_count words from the SIPO scan buffer, one op at a time, into a
// 2-entry output FIFO streamed out on valid/ready with a last-word marker.
`timescale 1ns/1ps
module sipo_buf_reader #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 64,
  parameter int CNT_W     = 7,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  sipo_buf_reader_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE, REQ, CMT, HOLD, DRAIN, FIN, ERR
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [7:0]        tmo_q;
  logic              val_op_q;
  logic              done_q;
  logic              error_q;

  logic              head_vld_q;
  logic              head_last_q;
  logic [DATA_W-1:0] head_dat_q;
  logic              tail_vld_q;
  logic              tail_last_q;
  logic [DATA_W-1:0] tail_dat_q;

  logic              push;
  logic              pop;
  logic              push_last;
  logic [1:0]        occ;
  logic [1:0]        occ_after;
  logic [CNT_W-1:0]  wc_clamp;
  logic              tmo_expired;

  assign push        = (state_q == CMT) && bus.buf_op_commit;
  assign pop         = head_vld_q && bus.out_ready;
  assign push_last   = (remaining_q == CNT_W'(1));
  assign occ         = {1'b0, head_vld_q} + {1'b0, tail_vld_q};
  assign occ_after   = occ + {1'b0, push} - {1'b0, pop};
  assign wc_clamp    = (word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_count;
  assign tmo_expired = (tmo_q == 8'(TIMEOUT - 1));

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign error          = error_q;
  assign bus.buf_val_op = val_op_q;
  assign bus.buf_op     = 1'b1;
  assign bus.out_valid  = head_vld_q;
  assign bus.out_data   = head_dat_q;
  assign bus.out_last   = head_last_q;

  // Timeout counter restarts on every state transition and saturates otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      tmo_q       <= '0;
      val_op_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tmo_q != 8'(TIMEOUT)) tmo_q <= tmo_q + 8'd1;
      case (state_q)
        IDLE: begin
          if (start) begin
            error_q <= 1'b0;
            tmo_q   <= '0;
            if (wc_clamp == '0) begin
              state_q <= FIN;
            end else begin
              remaining_q <= wc_clamp;
              val_op_q    <= 1'b1;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.buf_op_ack) begin
            val_op_q <= 1'b0;
            tmo_q    <= '0;
            state_q  <= CMT;
          end else if (tmo_expired) begin
            val_op_q <= 1'b0;
            tmo_q    <= '0;
            state_q  <= ERR;
          end
        end
        CMT: begin
          if (bus.buf_op_commit) begin
            remaining_q <= remaining_q - CNT_W'(1);
            tmo_q       <= '0;
            if (push_last) begin
              state_q <= DRAIN;
            end else if (occ_after <= 2'd1) begin
              val_op_q <= 1'b1;
              state_q  <= REQ;
            end else begin
              state_q <= HOLD;
            end
          end else if (tmo_expired) begin
            tmo_q   <= '0;
            state_q <= ERR;
          end
        end
        HOLD: begin
          if (occ <= 2'd1) begin
            val_op_q <= 1'b1;
            tmo_q    <= '0;
            state_q  <= REQ;
          end
        end
        DRAIN: begin
          if (occ == 2'd0) begin
            tmo_q   <= '0;
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          tmo_q   <= '0;
          state_q <= IDLE;
        end
        ERR: begin
          error_q <= 1'b1;
          done_q  <= 1'b1;
          tmo_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Head register feeds the outputs directly; tail only fills while the head is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_vld_q  <= 1'b0;
      head_last_q <= 1'b0;
      head_dat_q  <= '0;
      tail_vld_q  <= 1'b0;
      tail_last_q <= 1'b0;
      tail_dat_q  <= '0;
    end else if (state_q == ERR) begin
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else if (!head_vld_q || pop) begin
      if (tail_vld_q) begin
        head_vld_q  <= 1'b1;
        head_dat_q  <= tail_dat_q;
        head_last_q <= tail_last_q;
        tail_vld_q  <= push;
        if (push) begin
          tail_dat_q  <= bus.buf_rdata;
          tail_last_q <= push_last;
        end
      end else begin
        head_vld_q <= push;
        if (push) begin
          head_dat_q  <= bus.buf_rdata;
          head_last_q <= push_last;
        end
      end
    end else if (push) begin
      tail_vld_q  <= 1'b1;
      tail_dat_q  <= bus.buf_rdata;
      tail_last_q <= push_last;
    end
  end

endmodule

// File: tb/tb_sipo_buf_reader.sv
// Directed bench for sipo_buf_reader: buffer model + scoreboard/monitor.
`timescale 1ns/1ps
module tb_sipo_buf_reader;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 7;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic              last;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic             busy, done, error;

  sipo_buf_reader_if #(.DATA_W(DATA_W)) bus();

  sipo_buf_reader #(.DATA_W(DATA_W), .MAX_WORDS(64), .CNT_W(CNT_W), .TIMEOUT(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  // Buffer model state
  bit          ack_en = 1'b1;
  logic        vo_prev = 1'b0;
  logic        ack_prev = 1'b0;
  logic [31:0] rd_base = '0;
  int          rd_idx = 0;
  int          ops = 0;

  // Monitor state
  int first_vld = -1;
  int done_cnt = 0;
  int done_cyc = -1;
  int vo_cnt = 0;
  int occ = 0;
  int occ_max = 0;
  int t0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Buffer: ack one cycle after seeing val_op, commit with data the cycle after ack.
  initial begin
    bus.buf_op_ack    = 1'b0;
    bus.buf_op_commit = 1'b0;
    bus.buf_rdata     = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.buf_op_ack    = 1'b0;
        bus.buf_op_commit = 1'b0;
        vo_prev  = 1'b0;
        ack_prev = 1'b0;
      end else begin
        logic a, c;
        a = vo_prev && !ack_prev && ack_en;
        c = ack_prev;
        if (c) begin
          bus.buf_rdata = rd_base + 32'(rd_idx);
          rd_idx++;
        end
        bus.buf_op_ack    = a;
        bus.buf_op_commit = c;
        if (a) ops++;
        vo_prev  = bus.buf_val_op;
        ack_prev = a;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        occ = 0;
      end else begin
        logic pop_now;
        pop_now = bus.out_valid && bus.out_ready;
        if (bus.out_valid && first_vld < 0) first_vld = cyc;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (bus.buf_val_op) vo_cnt++;
        if (occ == 2) check("no_req_when_full", {31'd0, bus.buf_val_op}, 32'd0);
        if (pop_now) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got 0x%0h expected none", bus.out_data);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("word_data", bus.out_data, e.dat);
            check("word_last", {31'd0, bus.out_last}, {31'd0, e.last});
          end
        end
        occ = occ + (bus.buf_op_commit ? 1 : 0) - (pop_now ? 1 : 0);
        if (occ > occ_max) occ_max = occ;
      end
    end
  end

  task automatic do_start(input int wc, input logic [31:0] base);
    int n;
    n = (wc > 64) ? 64 : wc;
    for (int i = 0; i < n; i++) exp_q.push_back('{dat: base + 32'(i), last: (i == n - 1)});
    rd_base    = base;
    rd_idx     = 0;
    first_vld  = -1;
    vo_cnt     = 0;
    ops        = 0;
    occ_max    = 0;
    start      = 1'b1;
    word_count = CNT_W'(wc);
    t0         = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int base_cnt;
    bit seen;
    base_cnt = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt > base_cnt) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int dc;
    reset         = 1'b1;
    start         = 1'b0;
    word_count    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",     {31'd0, busy},           32'd0);
    check("rst_done",     {31'd0, done},           32'd0);
    check("rst_error",    {31'd0, error},          32'd0);
    check("rst_val_op",   {31'd0, bus.buf_val_op}, 32'd0);
    check("rst_buf_op",   {31'd0, bus.buf_op},     32'd1);
    check("rst_out_vld",  {31'd0, bus.out_valid},  32'd0);
    check("rst_out_last", {31'd0, bus.out_last},   32'd0);
    check("rst_out_data", bus.out_data,            32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic 4-word drain, consumer always ready
    bus.out_ready = 1'b1;
    dc = done_cnt;
    do_start(4, 32'hA0);
    check("t1_val_op_c1", {31'd0, bus.buf_val_op}, 32'd1);
    check("t1_busy",      {31'd0, busy},           32'd1);
    wait_done(100, "t1_done");
    check("t1_done_cyc",   32'(done_cyc),   32'(t0 + 16));
    check("t1_first_vld",  32'(first_vld),  32'(t0 + 4));
    check("t1_all_words",  32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("t1_one_done",   32'(done_cnt - dc), 32'd1);

    // 64 words with consumer stalled until cycle 20
    bus.out_ready = 1'b0;
    do_start(64, 32'h1000);
    while (cyc < t0 + 19) @(negedge clk);
    #2;
    check("t2_occ_stall", 32'(occ), 32'd2);
    @(negedge clk);
    bus.out_ready = 1'b1;
    wait_done(600, "t2_done");
    check("t2_all_words", 32'(exp_q.size()), 32'd0);
    check("t2_ops",       32'(ops),          32'd64);
    check("t2_occ_max",   32'(occ_max),      32'd2);
    check("t2_error",     {31'd0, error},    32'd0);
    repeat (2) @(negedge clk);

    // Zero-length drain
    do_start(0, 32'h0);
    wait_done(10, "t3_done");
    check("t3_done_cyc", 32'(done_cyc), 32'(t0 + 2));
    check("t3_no_req",   32'(vo_cnt),   32'd0);
    check("t3_error",    {31'd0, error}, 32'd0);
    repeat (2) @(negedge clk);

    // Oversize count clamps to 64
    do_start(100, 32'h2000);
    wait_done(600, "t4_done");
    check("t4_ops",       32'(ops),          32'd64);
    check("t4_all_words", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    // Ack never arrives -> timeout error, then recovery
    ack_en = 1'b0;
    do_start(3, 32'h3000);
    wait_done(400, "t5_done");
    check("t5_done_cyc", 32'(done_cyc),    32'(t0 + 257));
    check("t5_error",    {31'd0, error},   32'd1);
    @(negedge clk);
    check("t5_fifo_empty", {31'd0, bus.out_valid}, 32'd0);
    check("t5_busy",       {31'd0, busy},          32'd0);
    exp_q.delete();
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    do_start(2, 32'h3100);
    check("t5_err_clear", {31'd0, error}, 32'd0);
    wait_done(100, "t5_recover_done");
    check("t5_recover_words", 32'(exp_q.size()), 32'd0);
    check("t5_recover_err",   {31'd0, error},    32'd0);
    repeat (2) @(negedge clk);

    // Reset mid-drain with one word held
    bus.out_ready = 1'b0;
    do_start(4, 32'h4000);
    while (cyc < t0 + 6) @(negedge clk);
    reset = 1'b1;
    dc = done_cnt;
    @(negedge clk);
    check("t6_out_vld", {31'd0, bus.out_valid},  32'd0);
    check("t6_val_op",  {31'd0, bus.buf_val_op}, 32'd0);
    check("t6_busy",    {31'd0, busy},           32'd0);
    check("t6_done",    {31'd0, done},           32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    #2;
    check("t6_no_done",    32'(done_cnt - dc),     32'd0);
    check("t6_still_empty", {31'd0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
